// File: rtl/ber_pkg.sv
`default_nettype none
// ---- ber_pkg : shared widths, FSM encoding and saturating add for rx_ber_checker (rev 1.0) ----
package ber_pkg;

  localparam int MAX_DLY_DEF = 64;
  localparam int WIN_DEF     = 256;
  localparam int DLY_W       = $clog2(MAX_DLY_DEF);
  localparam int WIN_W       = $clog2(WIN_DEF) + 1;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } ber_state_e;

  // Adds a small increment and clamps at the all-ones value of a w-bit counter.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [1:0]  inc,
                                          input int unsigned w);
    logic [63:0] mx;
    logic [64:0] s;
    mx = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    s  = {1'b0, a} + {63'd0, inc};
    return (s > {1'b0, mx}) ? mx : s[63:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ref_delay_line.sv
`default_nettype none
// ---- ref_delay_line : valid-gated 2-bit reference history with selectable tap (rev 1.0) ----
module ref_delay_line #(
  parameter int DEPTH = 64,
  parameter int SEL_W = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             shift_en,
  input  logic [1:0]       din,
  input  logic [SEL_W-1:0] sel,
  output logic [1:0]       dout
);

  logic [DEPTH-1:0][1:0] hist_q;
  logic [DEPTH-1:0][1:0] hist_d;

  // Entry 0 holds the newest reference symbol, entry k the one k symbols older.
  always_comb begin
    hist_d = hist_q;
    if (shift_en) begin
      hist_d = {hist_q[DEPTH-2:0], din};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign dout = hist_q[sel];

endmodule
`default_nettype wire

// File: rtl/rx_ber_checker.sv
`default_nettype none
// ---- rx_ber_checker : QPSK hard slicer and BER checker with delay search FSM (rev 1.0) ----
module rx_ber_checker
  import ber_pkg::*;
#(
  parameter int DWIDTH     = 9,
  parameter int MAX_DLY    = MAX_DLY_DEF,
  parameter int WIN        = WIN_DEF,
  parameter int LOCK_THR   = 16,
  parameter int UNLOCK_THR = 64,
  parameter int CNT_W      = 32
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       valid_in,
  input  logic [DWIDTH-1:0]          rx_I,
  input  logic [DWIDTH-1:0]          rx_Q,
  input  logic                       ref_bI,
  input  logic                       ref_bQ,
  input  logic                       resync,
  input  logic                       clr_stats,
  output logic                       dec_valid,
  output logic                       dec_bI,
  output logic                       dec_bQ,
  output logic                       locked,
  output logic [$clog2(MAX_DLY)-1:0] delay_sel,
  output logic [CNT_W-1:0]           err_count,
  output logic [CNT_W-1:0]           bit_count
);

  localparam int SEL_W = $clog2(MAX_DLY);
  localparam int CW    = $clog2(WIN) + 1;
  localparam int SUM_W = $clog2(WIN) + 2;

  ber_state_e        state_q, state_d;
  logic              dec_valid_q, dec_valid_d;
  logic              dec_bI_q, dec_bI_d;
  logic              dec_bQ_q, dec_bQ_d;
  logic [SEL_W-1:0]  dly_q, dly_d;
  logic [CW-1:0]     win_cnt_q, win_cnt_d;
  logic [SUM_W-1:0]  win_sum_q, win_sum_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic [CNT_W-1:0]  bit_count_q, bit_count_d;

  logic [1:0]        refd;
  logic [1:0]        sym_err;
  logic [SUM_W-1:0]  win_total;
  logic              win_last;

  // Only the sign bits feed the slicer; the magnitude bits are intentionally ignored.
  logic unused_mag;
  assign unused_mag = ^{rx_I[DWIDTH-2:0], rx_Q[DWIDTH-2:0]};

  ref_delay_line #(
    .DEPTH (MAX_DLY),
    .SEL_W (SEL_W)
  ) u_ref_delay_line (
    .clk      (clk),
    .rstn     (rstn),
    .shift_en (valid_in),
    .din      ({ref_bI, ref_bQ}),
    .sel      (dly_q),
    .dout     (refd)
  );

  assign sym_err   = {1'b0, dec_bI_q ^ refd[1]} + {1'b0, dec_bQ_q ^ refd[0]};
  assign win_total = win_sum_q + SUM_W'(sym_err);
  assign win_last  = (win_cnt_q == CW'(WIN - 1));

  always_comb begin
    state_d     = state_q;
    dec_valid_d = valid_in;
    dec_bI_d    = valid_in ? rx_I[DWIDTH-1] : dec_bI_q;
    dec_bQ_d    = valid_in ? rx_Q[DWIDTH-1] : dec_bQ_q;
    dly_d       = dly_q;
    win_cnt_d   = win_cnt_q;
    win_sum_d   = win_sum_q;
    err_count_d = err_count_q;
    bit_count_d = bit_count_q;

    if (dec_valid_q) begin
      win_cnt_d = win_cnt_q + CW'(1);
      win_sum_d = win_total;
      if (state_q == LOCKED) begin
        err_count_d = CNT_W'(sat_add(64'(err_count_q), sym_err, CNT_W));
        bit_count_d = CNT_W'(sat_add(64'(bit_count_q), 2'd2, CNT_W));
      end
      if (win_last) begin
        win_cnt_d = '0;
        win_sum_d = '0;
        if (state_q == SEARCH) begin
          if (win_total <= SUM_W'(LOCK_THR)) begin
            state_d = LOCKED;
          end else begin
            dly_d = dly_q + SEL_W'(1);
          end
        end else if (win_total > SUM_W'(UNLOCK_THR)) begin
          state_d = SEARCH;
          dly_d   = dly_q + SEL_W'(1);
        end
      end
    end

    if (resync) begin
      state_d   = SEARCH;
      dly_d     = '0;
      win_cnt_d = '0;
      win_sum_d = '0;
    end

    if (clr_stats) begin
      err_count_d = '0;
      bit_count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= SEARCH;
      dec_valid_q <= 1'b0;
      dec_bI_q    <= 1'b0;
      dec_bQ_q    <= 1'b0;
      dly_q       <= '0;
      win_cnt_q   <= '0;
      win_sum_q   <= '0;
      err_count_q <= '0;
      bit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      dec_valid_q <= dec_valid_d;
      dec_bI_q    <= dec_bI_d;
      dec_bQ_q    <= dec_bQ_d;
      dly_q       <= dly_d;
      win_cnt_q   <= win_cnt_d;
      win_sum_q   <= win_sum_d;
      err_count_q <= err_count_d;
      bit_count_q <= bit_count_d;
    end
  end

  assign dec_valid = dec_valid_q;
  assign dec_bI    = dec_bI_q;
  assign dec_bQ    = dec_bQ_q;
  assign locked    = (state_q == LOCKED);
  assign delay_sel = dly_q;
  assign err_count = err_count_q;
  assign bit_count = bit_count_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_ber_checker.sv
`default_nettype none
// ---- tb_rx_ber_checker : directed self-checking bench for rx_ber_checker (rev 1.0) ----
module tb_rx_ber_checker;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        valid_in = 1'b0;
  logic [8:0]  rx_I = '0;
  logic [8:0]  rx_Q = '0;
  logic        ref_bI = 1'b0;
  logic        ref_bQ = 1'b0;
  logic        resync = 1'b0;
  logic        clr_stats = 1'b0;
  logic        dec_valid, dec_bI, dec_bQ, locked;
  logic [5:0]  delay_sel;
  logic [31:0] err_count, bit_count;

  int errors = 0;
  int checks = 0;
  int chan_d = 5;
  logic [1:0] tx_hist[$];

  rx_ber_checker #(
    .DWIDTH(9), .MAX_DLY(64), .WIN(256), .LOCK_THR(16), .UNLOCK_THR(64), .CNT_W(32)
  ) dut (
    .clk(clk), .rstn(rstn), .valid_in(valid_in), .rx_I(rx_I), .rx_Q(rx_Q),
    .ref_bI(ref_bI), .ref_bQ(ref_bQ), .resync(resync), .clr_stats(clr_stats),
    .dec_valid(dec_valid), .dec_bI(dec_bI), .dec_bQ(dec_bQ), .locked(locked),
    .delay_sel(delay_sel), .err_count(err_count), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] map_bit(input logic b);
    return b ? 9'h1C0 : 9'h040;
  endfunction

  // One valid symbol: reference is the fresh tx symbol, rx is the tx symbol chan_d ago.
  task automatic send_sym(input logic flip_i);
    logic [1:0] tx, rxb;
    tx = 2'($urandom_range(0, 3));
    if (tx_hist.size() > 100) void'(tx_hist.pop_front());
    tx_hist.push_back(tx);
    if (tx_hist.size() > chan_d) rxb = tx_hist[tx_hist.size() - 1 - chan_d];
    else rxb = 2'b00;
    rxb[1] = rxb[1] ^ flip_i;
    valid_in = 1'b1;
    rx_I = map_bit(rxb[1]);
    rx_Q = map_bit(rxb[0]);
    ref_bI = tx[1];
    ref_bQ = tx[0];
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    idle(2);
    checks++; if (locked !== 1'b0 || dec_valid !== 1'b0 || dec_bI !== 1'b0 || dec_bQ !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got lk=%b dv=%b bi=%b bq=%b required all 0", locked, dec_valid, dec_bI, dec_bQ); end
    checks++; if (delay_sel !== 6'd0) begin errors++; $display("FAIL reset_delay: got %0d required 0", delay_sel); end
    checks++; if (err_count !== 32'd0 || bit_count !== 32'd0) begin
      errors++; $display("FAIL reset_counts: got err=%0d bit=%0d required 0/0", err_count, bit_count); end
    rstn = 1'b1;
    idle(1);
  endtask

  task automatic test_lock_d5;
    repeat (1535) send_sym(1'b0);
    idle(1);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early: got locked=%b required 0", locked); end
    checks++; if (delay_sel !== 6'd5) begin errors++; $display("FAIL search_delay: got %0d required 5", delay_sel); end
    send_sym(1'b0);
    idle(1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_rise: got locked=%b required 1", locked); end
    checks++; if (delay_sel !== 6'd5) begin errors++; $display("FAIL lock_delay: got %0d required 5", delay_sel); end
    checks++; if (err_count !== 32'd0 || bit_count !== 32'd0) begin
      errors++; $display("FAIL lock_counts0: got err=%0d bit=%0d required 0/0", err_count, bit_count); end
    repeat (100) send_sym(1'b0);
    idle(1);
    checks++; if (err_count !== 32'd0 || bit_count !== 32'd200) begin
      errors++; $display("FAIL clean_counts: got err=%0d bit=%0d required 0/200", err_count, bit_count); end
  endtask

  task automatic test_error_rate;
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    checks++; if (err_count !== 32'd0 || bit_count !== 32'd0) begin
      errors++; $display("FAIL clr_stats: got err=%0d bit=%0d required 0/0", err_count, bit_count); end
    for (int k = 0; k < 512; k++) send_sym(k % 16 == 0);
    idle(1);
    checks++; if (err_count !== 32'd32 || bit_count !== 32'd1024) begin
      errors++; $display("FAIL ber_counts: got err=%0d bit=%0d required 32/1024", err_count, bit_count); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL ber_lock_held: got locked=%b required 1", locked); end
  endtask

  task automatic test_delay_change;
    logic [31:0] saved;
    bit found;
    chan_d = 9;
    found = 1'b0;
    for (int k = 0; k < 1500 && !found; k++) begin
      send_sym(1'b0);
      if (locked === 1'b0) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL unlock_timeout: got locked=1 required 0 within 1500 symbols"); end
    checks++; if (delay_sel !== 6'd6) begin errors++; $display("FAIL unlock_delay: got %0d required 6", delay_sel); end
    saved = err_count;
    found = 1'b0;
    for (int k = 0; k < 4000 && !found; k++) begin
      send_sym(1'b0);
      if (locked === 1'b1) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL relock_timeout: got locked=0 required 1 within 4000 symbols"); end
    checks++; if (delay_sel !== 6'd9) begin errors++; $display("FAIL relock_delay: got %0d required 9", delay_sel); end
    checks++; if (err_count !== saved) begin errors++; $display("FAIL err_held: got %0d required %0d", err_count, saved); end
  endtask

  task automatic test_slicer;
    logic [8:0] vi[5] = '{9'h000, 9'h1FF, 9'h000, 9'h1FF, 9'h100};
    logic [8:0] vq[5] = '{9'h000, 9'h1FF, 9'h1FF, 9'h000, 9'h0FF};
    logic [1:0] ex[5] = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b10};
    logic [1:0] tx;
    for (int k = 0; k < 5; k++) begin
      tx = 2'($urandom_range(0, 3));
      tx_hist.push_back(tx);
      valid_in = 1'b1; rx_I = vi[k]; rx_Q = vq[k]; ref_bI = tx[1]; ref_bQ = tx[0];
      @(negedge clk);
      valid_in = 1'b0;
      checks++; if (dec_valid !== 1'b1 || {dec_bI, dec_bQ} !== ex[k]) begin
        errors++; $display("FAIL slice_%0d: got dv=%b bits=%b%b required dv=1 bits=%b", k, dec_valid, dec_bI, dec_bQ, ex[k]); end
      @(negedge clk);
      checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL slice_gap_%0d: got dv=%b required 0", k, dec_valid); end
    end
  endtask

  task automatic test_saturation;
    force dut.bit_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.bit_count_q;
    @(negedge clk);
    send_sym(1'b0);
    send_sym(1'b0);
    idle(1);
    checks++; if (bit_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL saturate: got %0h required ffffffff", bit_count); end
    send_sym(1'b1);
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    checks++; if (err_count !== 32'd0 || bit_count !== 32'd0) begin
      errors++; $display("FAIL clr_beats_inc: got err=%0d bit=%0d required 0/0", err_count, bit_count); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL clr_fsm: got locked=%b required 1", locked); end
  endtask

  task automatic test_resync;
    bit found;
    for (int k = 0; k < 10; k++) send_sym(k == 0);
    idle(1);
    checks++; if (err_count !== 32'd1 || bit_count !== 32'd20) begin
      errors++; $display("FAIL pre_resync: got err=%0d bit=%0d required 1/20", err_count, bit_count); end
    resync = 1'b1;
    @(negedge clk);
    resync = 1'b0;
    checks++; if (locked !== 1'b0 || delay_sel !== 6'd0) begin
      errors++; $display("FAIL resync_state: got locked=%b dly=%0d required 0/0", locked, delay_sel); end
    checks++; if (err_count !== 32'd1 || bit_count !== 32'd20) begin
      errors++; $display("FAIL resync_keeps_stats: got err=%0d bit=%0d required 1/20", err_count, bit_count); end
    resync = 1'b1; clr_stats = 1'b1;
    @(negedge clk);
    resync = 1'b0; clr_stats = 1'b0;
    checks++; if (err_count !== 32'd0 || bit_count !== 32'd0 || delay_sel !== 6'd0) begin
      errors++; $display("FAIL resync_clr: got err=%0d bit=%0d dly=%0d required 0/0/0", err_count, bit_count, delay_sel); end
    found = 1'b0;
    for (int k = 0; k < 3000 && !found; k++) begin
      send_sym(1'b0);
      if (locked === 1'b1) found = 1'b1;
    end
    checks++; if (!found || delay_sel !== 6'd9) begin
      errors++; $display("FAIL resync_relock: got locked=%b dly=%0d required 1/9", locked, delay_sel); end
  endtask

  task automatic test_async_reset;
    int n;
    bit found;
    repeat (100) send_sym(1'b0);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    checks++; if (locked !== 1'b0 || delay_sel !== 6'd0 || err_count !== 32'd0 || bit_count !== 32'd0 || dec_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset: got lk=%b dly=%0d err=%0d bit=%0d dv=%b required all 0",
                         locked, delay_sel, err_count, bit_count, dec_valid); end
    @(negedge clk);
    rstn = 1'b1;
    found = 1'b0;
    n = 0;
    for (int k = 0; k < 3500 && !found; k++) begin
      send_sym(1'b0);
      n++;
      if (locked === 1'b1) found = 1'b1;
    end
    checks++; if (!found || delay_sel !== 6'd9) begin
      errors++; $display("FAIL reset_relock: got locked=%b dly=%0d required 1/9", locked, delay_sel); end
    checks++; if (n !== 2561) begin errors++; $display("FAIL reset_relock_time: got %0d symbols required 2561", n); end
  endtask

  initial begin
    test_reset();
    test_lock_d5();
    test_error_rate();
    test_delay_change();
    test_slicer();
    test_saturation();
    test_resync();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete, required finish before 5ms");
    $fatal(1);
  end

endmodule
`default_nettype wire
